// File: rtl/count_pkg.sv
// Shared definitions for the loadable wrap counter and its load-side controller.
package count_pkg;

    localparam int COUNT_W       = 4;
    localparam int COUNT_SET_LAT = 2;   // cycles from set assertion to the counter loading set_num

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        ISSUE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } count_ld_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_load_ctrl.sv
// Load-side initiator for the 4-bit wrap counter: drives set/set_num and optionally
// verifies the load by reading number/zero back (enabled by COUNT_LOAD_CTRL_VERIFY_EN).
module count_load_ctrl
    import count_pkg::*;
#(
    parameter int W     = COUNT_W,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the requester holds req_valid/req_num until then, and they are ignored otherwise.
    input  logic             req_valid,
    input  logic [W-1:0]     req_num,
    output logic             req_ready,
    output logic             set,
    output logic [W-1:0]     set_num,
    input  logic [W-1:0]     number,
    input  logic             zero,
    output logic             done,
    output logic             match,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       state_dbg
);

    count_ld_state_t state_q, state_d;
    logic [W-1:0]    num_q;
    logic            err_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // set_num comes straight from this register so it only moves on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q <= '0;
        end else if (req_valid && req_ready) begin
            num_q <= req_num;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        set       = 1'b0;
        done      = 1'b0;
        case (state_q)
            INIT: begin
                state_d = IDLE;
            end
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                set     = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                state_d = CHECK;
            end
            CHECK: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign set_num   = num_q;
    assign state_dbg = state_q;

`ifdef COUNT_LOAD_CTRL_VERIFY_EN
    logic verify_ok;

    assign verify_ok = (number == num_q) && (zero == (number == '0));
    assign match     = done && verify_ok;
    assign err_inc   = done && !verify_ok;
`else
    logic unused_readback;

    assign unused_readback = ^{number, zero};
    assign match           = 1'b1;
    assign err_inc         = 1'b0;
`endif

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (err_inc),
        .count(err_cnt)
    );

endmodule

// File: tb/tb_count_load_ctrl.sv
// Bench for count_load_ctrl driving a behavioural wrap counter with number fault injection.
module tb_count_load_ctrl;
    import count_pkg::*;

    localparam int W     = 4;
    localparam int ERR_W = 8;
`ifdef COUNT_LOAD_CTRL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [W-1:0]     req_num = '0;
    logic             fault = 1'b0;
    logic             req_ready, set, done, match;
    logic [W-1:0]     set_num, number;
    logic             zero;
    logic [ERR_W-1:0] err_cnt;
    logic [2:0]       state_dbg;

    always #5 clk = ~clk;

    count_load_ctrl #(.W(W), .ERR_W(ERR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_num  (req_num),
        .req_ready(req_ready),
        .set      (set),
        .set_num  (set_num),
        .number   (number),
        .zero     (zero),
        .done     (done),
        .match    (match),
        .err_cnt  (err_cnt),
        .state_dbg(state_dbg)
    );

    // Wrap counter: one dead cycle after reset, set registered once, then loads set_num.
    logic [W-1:0] cnt_q;
    logic         set_q, dead_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            set_q  <= 1'b0;
            dead_q <= 1'b1;
        end else begin
            dead_q <= 1'b0;
            set_q  <= set;
            if (!dead_q) begin
                cnt_q <= set_q ? set_num : cnt_q + W'(1);
            end
        end
    end

    assign number = fault ? W'(7) : cnt_q;
    assign zero   = (cnt_q == '0);

    typedef struct {
        logic         rst;
        logic         valid;
        logic [W-1:0] num;
        logic         ready;
        logic         set;
        logic [W-1:0] set_num;
        logic         done;
        logic         match;
    } vec_t;

    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           m_acc = -1000;
    int           m_err = 0;
    bit           m_init = 1'b1;
    logic [W-1:0] m_cap = '0;
    logic         s_ready, s_set, s_done, s_match;
    logic [W-1:0] s_set_num;
    logic [ERR_W-1:0] s_err;
    logic [2:0]   s_state;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // One cycle: drive inputs, sample and check on the falling edge, advance the model.
    task automatic step(input logic r, input logic v, input logic [W-1:0] n, input logic f,
                        output bit acc);
        int           age;
        logic         e_ready, e_set, e_done, e_ok, e_match;
        logic [ERR_W-1:0] e_err;
        logic [2:0]   e_st;
        rst = r; req_valid = v; req_num = n; fault = f;
        @(negedge clk);
        age     = cyc - m_acc;
        e_ready = !m_init && (age >= 4);
        e_set   = (age == 1);
        e_done  = (age == COUNT_SET_LAT + 1);
        e_ok    = !f || (m_cap == W'(7));
        e_match = VERIFY ? (e_done && e_ok) : 1'b1;
        e_err   = VERIFY ? ERR_W'(m_err) : '0;
        if (m_init)      e_st = INIT;
        else if (age == 1) e_st = ISSUE;
        else if (age == 2) e_st = HOLD;
        else if (age == 3) e_st = CHECK;
        else             e_st = IDLE;
        s_ready = req_ready; s_set = set; s_set_num = set_num; s_done = done;
        s_match = match; s_err = err_cnt; s_state = state_dbg;
        vectors++;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("set", 32'(set), 32'(e_set));
        chk("set_num", 32'(set_num), 32'(m_cap));
        chk("done", 32'(done), 32'(e_done));
        chk("match", 32'(match), 32'(e_match));
        chk("err_cnt", 32'(err_cnt), 32'(e_err));
        chk("state", 32'(state_dbg), 32'(e_st));
        acc = req_ready && v;
        if (r) begin
            m_init = 1'b1; m_acc = -1000; m_cap = '0; m_err = 0;
        end else if (m_init) begin
            m_init = 1'b0;
        end else begin
            if (e_done && !e_ok && m_err < 255) m_err++;
            if (e_ready && v) begin
                m_acc = cyc;
                m_cap = n;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [W-1:0] n, input logic f, output int acc_cyc);
        bit a;
        int k;
        a = 1'b0;
        k = 0;
        acc_cyc = cyc;
        while (!a && k < 20) begin
            acc_cyc = cyc;
            step(1'b0, 1'b1, n, f, a);
            k++;
        end
        if (!a) begin
            miscompares++;
            $display("FAIL send_timeout cyc=%0d actual=no_accept required=accept", cyc);
        end
    endtask

    task automatic idle(input int k, input logic f);
        bit a;
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, W'($urandom_range(0, 15)), f, a);
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [W-1:0] n,
                                input logic ry, input logic st, input logic [W-1:0] sn,
                                input logic dn, input logic mt);
        vec_t t;
        t.rst = r; t.valid = v; t.num = n; t.ready = ry; t.set = st;
        t.set_num = sn; t.done = dn; t.match = mt;
        return t;
    endfunction

    initial begin
        vec_t tbl[7];
        bit   a;
        int   a0, a1, a2, tmp;
        logic idle_match;

        idle_match = VERIFY ? 1'b0 : 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset release with a request already waiting.
        tbl[0] = mk(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, idle_match);
        tbl[1] = mk(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, idle_match);
        tbl[2] = mk(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, idle_match);
        tbl[3] = mk(1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 4'd5, 1'b0, idle_match);
        tbl[4] = mk(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 4'd5, 1'b0, idle_match);
        tbl[5] = mk(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1);
        tbl[6] = mk(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 4'd5, 1'b0, idle_match);
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rst, tbl[i].valid, tbl[i].num, 1'b0, a);
            chk("tbl_ready", 32'(s_ready), 32'(tbl[i].ready));
            chk("tbl_set", 32'(s_set), 32'(tbl[i].set));
            chk("tbl_set_num", 32'(s_set_num), 32'(tbl[i].set_num));
            chk("tbl_done", 32'(s_done), 32'(tbl[i].done));
            chk("tbl_match", 32'(s_match), 32'(tbl[i].match));
        end

        // Back-to-back 3, 9, 0.
        send(4'd3, 1'b0, a0);
        send(4'd9, 1'b0, a1);
        send(4'd0, 1'b0, a2);
        chk("accept_gap_1", 32'(a1 - a0), 32'd4);
        chk("accept_gap_2", 32'(a2 - a1), 32'd4);
        idle(COUNT_SET_LAT, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, a);
        chk("zero_load_done", 32'(s_done), 32'd1);
        chk("zero_load_match", 32'(s_match), 32'd1);

        // Load 15, then idle while the counter wraps.
        send(4'd15, 1'b0, tmp);
        idle(COUNT_SET_LAT, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, a);
        chk("load15_match", 32'(s_match), 32'd1);
        idle(2, 1'b0);
        chk("load15_err", 32'(s_err), 32'd0);

        // Corrupted readback on a load of 6, then saturation.
        send(4'd6, 1'b1, tmp);
        idle(4, 1'b1);
        chk("fault_err_1", 32'(s_err), VERIFY ? 32'd1 : 32'd0);
        for (int i = 0; i < 300; i++) send(4'd6, 1'b1, tmp);
        idle(4, 1'b1);
        chk("fault_err_sat", 32'(s_err), VERIFY ? 32'd255 : 32'd0);

        // Reset during HOLD.
        send(4'd4, 1'b0, tmp);
        idle(1, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, a);
        chk("hold_state", 32'(s_state), 32'(HOLD));
        step(1'b0, 1'b0, 4'd0, 1'b0, a);
        chk("rst_state_init", 32'(s_state), 32'(INIT));
        chk("rst_no_done", 32'(s_done), 32'd0);
        chk("rst_no_set", 32'(s_set), 32'd0);
        chk("rst_err_clear", 32'(s_err), 32'd0);
        send(4'd11, 1'b0, tmp);
        idle(COUNT_SET_LAT, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, a);
        chk("after_rst_done", 32'(s_done), 32'd1);
        chk("after_rst_match", 32'(s_match), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 60) == 0), 1'($urandom_range(0, 1)),
                 W'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_load_ctrl.md
# count_load_ctrl

Load-side initiator for the team's 4-bit loadable wrap counter. It accepts load requests on a valid/ready handshake and drives the counter's `set`/`set_num` pins. It holds `set_num` stable across the counter's internal one-cycle `set` registration and, optionally, reads back `number`/`zero` to confirm the load. It sits between the control sequencer and the counter instance; the counter's outputs feed back into it.

## Interface
- `W`, 4: counter width; must match the counter instance.
- `ERR_W`, 8: width of the mismatch counter.
- `clk` input, 1: clock.
- `rst` input, 1: synchronous, active-high reset.
- `req_valid` input, 1: load request present.
- `req_num` input, W: value to load.
- `req_ready` output, 1: request accepted when `req_valid && req_ready` at a rising edge.
- `set` output, 1: to counter `set`.
- `set_num` output, W: to counter `set_num`.
- `number` input, W: from counter `number`.
- `zero` input, 1: from counter `zero`.
- `done` output, 1: one-cycle pulse when a load completes.
- `match` output, 1: valid with `done`; load verified.
- `err_cnt` output, ERR_W: saturating count of failed verifications.

## Operation
- States:
  - INIT: one cycle after reset release; covers the counter's start-up dead cycle; `req_ready` = 0.
  - IDLE: `req_ready` = 1.
  - ISSUE: `set` = 1.
  - HOLD: `set` = 0, `set_num` still held.
  - CHECK: `done` = 1.
- Transitions:
  - INIT→IDLE unconditionally.
  - IDLE→ISSUE on handshake; `req_num` is captured into an internal register.
  - ISSUE→HOLD→CHECK→IDLE unconditionally.
- `set_num` always equals the captured register. It changes only on acceptance and keeps its last value while idle, so the counter never sees a glitch.
- `req_ready` is high only in IDLE. There is no pipelining: one load per 4 cycles maximum.
- Verification, in CHECK:
  - `match` = (`number` == captured) && (`zero` == (`number` == 0)).
  - If `match` = 0, `err_cnt` increments, saturating at all-ones.
- `req_num` and `req_valid` outside IDLE are ignored. The requester must hold `req_valid` until ready.

## Timing
- Reset values:
  - state = INIT.
  - `req_ready` = 0, `set` = 0, `set_num` = 0.
  - `done` = 0, `match` = 0, `err_cnt` = 0.
- Acceptance edge = cycle 0. In the following cycles:
  - Cycle 1 (ISSUE): `set` = 1.
  - Cycle 2 (HOLD): counter loads `set_num` at end of cycle.
  - Cycle 3 (CHECK): `number` == N expected; `done` pulses.
  - Cycle 4: IDLE, `req_ready` = 1.
- Latency from acceptance to `done` is 3 cycles.
- `set` is a single-cycle pulse per request, never back-to-back.
- Reset asserted mid-operation:
  - Aborts immediately; no `done` pulse.
  - `set` = 0 on the next cycle.
  - `err_cnt` clears.
- Loading the value the counter would reach naturally (e.g. `number` 14 in HOLD, `req_num` 15) is still a load and must verify `match` = 1.
- Loading 0 requires `zero` = 1 in CHECK.
- Loading 15 then leaving the counter idle: it wraps to 0 one cycle after CHECK. This is not checked.

## Configuration
- `COUNT_LOAD_CTRL_VERIFY_EN` defined:
  - CHECK state, `match`, and `err_cnt` logic are present as described.
- Undefined:
  - CHECK still exists for identical timing and `done` still pulses in cycle 3.
  - `match` is tied to 1 and `err_cnt` is tied to 0.
  - `number` and `zero` are unused.

## Structure
- Shared package `count_pkg`:
  - state enum `count_ld_state_t` (INIT, IDLE, ISSUE, HOLD, CHECK).
  - `COUNT_W` = 4.
  - `COUNT_SET_LAT` = 2 (cycles from `set` assertion to load).
- One sub-module: `sat_counter` (parameter width, synchronous clear, increment enable, saturating). It is used for `err_cnt` and is reusable elsewhere.
- Bench instantiates this block driving the real counter, plus a fault-injection mode that corrupts `number`.

## Test plan
- Reset released, `req_valid` = 1 with `req_num` = 5 from the first cycle:
  - `req_ready` = 0 for one cycle, then 1.
  - `set` pulses once and `set_num` = 5 for 3 cycles.
  - `done`/`match` = 1 with `number` = 5.
- Back-to-back requests 3, 9, 0:
  - Each gets `done` exactly 3 cycles after its acceptance.
  - Accepts are 4 cycles apart.
  - The load of 0 shows `zero` = 1 and `match` = 1.
- Load 15, then idle: `match` = 1 in CHECK, counter reads 0 the next cycle, `err_cnt` stays 0.
- Fault injection forces `number` = 7 during a load of 6:
  - `match` = 0 and `err_cnt` = 1.
  - 300 repeated faults saturate `err_cnt` at 255.
- Reset asserted in HOLD:
  - No `done`, `set` stays 0, state returns via INIT.
  - `err_cnt` = 0.
  - The next request completes normally.
- Build without `COUNT_LOAD_CTRL_VERIFY_EN` plus fault injection: `done` timing unchanged, `match` = 1, `err_cnt` = 0.
